// File: rtl/stage_decode.sv
// RV32I decode stage: register file, instruction hold buffer, RAW interlock
// and the execute pipeline register.
module stage_decode #(
   parameter int WB_BYPASS = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        de_valid,
   input  logic [31:0] de_insn,
   input  logic [31:0] de_pc,
   output logic        de_stall,
   input  logic        flush,
   input  logic        ex_stall,
   input  logic        mm_valid,
   input  logic        mm_wen,
   input  logic [4:0]  mm_rd,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_val,
   output logic [31:0] ex_rs2_val,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd,
   output logic        ex_wen,
   output logic [3:0]  ex_alu_op,
   output logic        ex_op1_pc,
   output logic        ex_op1_zero,
   output logic        ex_op2_imm,
   output logic        ex_load,
   output logic        ex_store,
   output logic        ex_branch,
   output logic        ex_jal,
   output logic        ex_jalr,
   output logic [2:0]  ex_funct3,
   output logic        ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {DIRECT, HELD} hold_state_t;

   hold_state_t hold_state;
   logic [31:0] hold_insn;
   logic [31:0] hold_pc;

   logic [31:0] cur_insn;
   logic [31:0] cur_pc;
   logic        cur_valid;

   logic [31:0] regs [1:31];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
   logic        is_store, is_opimm, is_op, is_misc, is_system;
   logic        illegal;
   logic        use_rs1, use_rs2;
   logic        rs1_hit, rs2_hit, hazard;
   logic [31:0] imm_d;
   logic [31:0] rs1_val, rs2_val;
   logic        wen_d;
   logic        alu_q;

   // In HELD the captured word stands in for fetch, whose bus is no longer valid.
   assign cur_insn  = (hold_state == HELD) ? hold_insn : de_insn;
   assign cur_pc    = (hold_state == HELD) ? hold_pc   : de_pc;
   assign cur_valid = (hold_state == HELD) ? 1'b1      : de_valid;

   assign opcode = cur_insn[6:0];
   assign rd     = cur_insn[11:7];
   assign funct3 = cur_insn[14:12];
   assign rs1    = cur_insn[19:15];
   assign rs2    = cur_insn[24:20];

   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_misc   = (opcode == OPC_MISC);
   assign is_system = (opcode == OPC_SYSTEM);

   assign illegal = (cur_insn[1:0] != 2'b11) ||
                    !(is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load ||
                      is_store || is_opimm || is_op || is_misc || is_system);

   assign use_rs1 = !(is_lui || is_auipc || is_jal);
   assign use_rs2 = is_op || is_branch || is_store;

   assign rs1_hit = use_rs1 && (rs1 != 5'd0) &&
                    ((ex_valid && ex_wen && (ex_rd == rs1)) ||
                     (mm_valid && mm_wen && (mm_rd == rs1)) ||
                     ((WB_BYPASS == 0) && wb_wen && (wb_rd == rs1)));
   assign rs2_hit = use_rs2 && (rs2 != 5'd0) &&
                    ((ex_valid && ex_wen && (ex_rd == rs2)) ||
                     (mm_valid && mm_wen && (mm_rd == rs2)) ||
                     ((WB_BYPASS == 0) && wb_wen && (wb_rd == rs2)));
   assign hazard  = rs1_hit || rs2_hit;

   assign de_stall = cur_valid && !flush && (hazard || ex_stall);

   assign wen_d = (rd != 5'd0) &&
                  (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op);
   assign alu_q = (is_op || (is_opimm && (funct3 == 3'b101))) && cur_insn[30];

   always_comb begin
      imm_d = {{20{cur_insn[31]}}, cur_insn[31:20]};
      if (is_store)
         imm_d = {{20{cur_insn[31]}}, cur_insn[31:25], cur_insn[11:7]};
      else if (is_branch)
         imm_d = {{19{cur_insn[31]}}, cur_insn[31], cur_insn[7], cur_insn[30:25],
                  cur_insn[11:8], 1'b0};
      else if (is_lui || is_auipc)
         imm_d = {cur_insn[31:12], 12'b0};
      else if (is_jal)
         imm_d = {{11{cur_insn[31]}}, cur_insn[31], cur_insn[19:12], cur_insn[20],
                  cur_insn[30:21], 1'b0};
   end

   // Write-first read when bypass is enabled; x0 is hardwired.
   always_comb begin
      rs1_val = '0;
      if (rs1 != 5'd0)
         rs1_val = ((WB_BYPASS != 0) && wb_wen && (wb_rd == rs1)) ? wb_data : regs[rs1];
   end

   always_comb begin
      rs2_val = '0;
      if (rs2 != 5'd0)
         rs2_val = ((WB_BYPASS != 0) && wb_wen && (wb_rd == rs2)) ? wb_data : regs[rs2];
   end

   always_ff @(posedge clk) begin
      if (wb_wen && (wb_rd != 5'd0))
         regs[wb_rd] <= wb_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_state <= DIRECT;
      end else begin
         case (hold_state)
            DIRECT: begin
               if (cur_valid && de_stall) begin
                  hold_state <= HELD;
                  hold_insn  <= de_insn;
                  hold_pc    <= de_pc;
               end
            end
            HELD: begin
               if (!de_stall || flush)
                  hold_state <= DIRECT;
            end
            default: hold_state <= DIRECT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_wen      <= 1'b0;
         ex_alu_op   <= '0;
         ex_op1_pc   <= 1'b0;
         ex_op1_zero <= 1'b0;
         ex_op2_imm  <= 1'b0;
         ex_load     <= 1'b0;
         ex_store    <= 1'b0;
         ex_branch   <= 1'b0;
         ex_jal      <= 1'b0;
         ex_jalr     <= 1'b0;
         ex_funct3   <= '0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (cur_valid && !hazard) begin
         ex_valid    <= 1'b1;
         ex_pc       <= cur_pc;
         ex_rs1_val  <= rs1_val;
         ex_rs2_val  <= rs2_val;
         ex_imm      <= imm_d;
         ex_rd       <= rd;
         ex_wen      <= wen_d;
         ex_alu_op   <= {alu_q, funct3};
         ex_op1_pc   <= is_auipc || is_jal || is_branch;
         ex_op1_zero <= is_lui;
         ex_op2_imm  <= !illegal && !is_op;
         ex_load     <= is_load;
         ex_store    <= is_store;
         ex_branch   <= is_branch;
         ex_jal      <= is_jal;
         ex_jalr     <= is_jalr;
         ex_funct3   <= funct3;
         ex_illegal  <= illegal;
      end else begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stage_decode.sv
// Scoreboard bench for stage_decode: expected execute-register contents are
// queued when an instruction is presented and compared when it issues.
module tb_stage_decode;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        de_valid = 1'b0;
   logic [31:0] de_insn = '0;
   logic [31:0] de_pc = '0;
   logic        de_stall;
   logic        flush = 1'b0;
   logic        ex_stall = 1'b0;
   logic        mm_valid = 1'b0;
   logic        mm_wen = 1'b0;
   logic [4:0]  mm_rd = '0;
   logic        wb_wen = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_wen;
   logic [3:0]  ex_alu_op;
   logic        ex_op1_pc, ex_op1_zero, ex_op2_imm;
   logic        ex_load, ex_store, ex_branch, ex_jal, ex_jalr;
   logic [2:0]  ex_funct3;
   logic        ex_illegal;

   stage_decode #(.WB_BYPASS(1)) dut (
      .clk(clk), .reset_n(reset_n), .de_valid(de_valid), .de_insn(de_insn), .de_pc(de_pc),
      .de_stall(de_stall), .flush(flush), .ex_stall(ex_stall),
      .mm_valid(mm_valid), .mm_wen(mm_wen), .mm_rd(mm_rd),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_alu_op(ex_alu_op),
      .ex_op1_pc(ex_op1_pc), .ex_op1_zero(ex_op1_zero), .ex_op2_imm(ex_op2_imm),
      .ex_load(ex_load), .ex_store(ex_store), .ex_branch(ex_branch), .ex_jal(ex_jal),
      .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic        wen;
      logic [3:0]  alu;
      logic        op1_pc, op1_zero, op2_imm, load, store, branch, jal, jalr;
      logic [2:0]  f3;
      logic        illegal;
   } ex_t;

   typedef struct {
      ex_t   e;
      ex_t   m;
      string name;
   } sb_t;

   ex_t         obs;
   sb_t         sb_q[$];
   logic [31:0] rf_m [0:31];
   int          n_checks = 0;
   int          n_fail = 0;

   assign obs = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_wen, ex_alu_op,
                 ex_op1_pc, ex_op1_zero, ex_op2_imm, ex_load, ex_store, ex_branch,
                 ex_jal, ex_jalr, ex_funct3, ex_illegal};

   function automatic ex_t mk(input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd,
                              input logic wen, input logic [3:0] alu, input logic [7:0] cls,
                              input logic [2:0] f3, input logic ill);
      return {pc, r1, r2, imm, rd, wen, alu, cls, f3, ill};
   endfunction

   function automatic ex_t mask_all();
      ex_t m;
      m = '1;
      return m;
   endfunction

   function automatic ex_t mask_noimm();
      ex_t m;
      m = '1;
      m.imm = '0;
      return m;
   endfunction

   function automatic ex_t mask_illegal();
      ex_t m;
      m = '0;
      m.pc = '1;  m.rd = '1;  m.wen = 1'b1;  m.f3 = '1;  m.illegal = 1'b1;
      m.load = 1'b1;  m.store = 1'b1;  m.branch = 1'b1;  m.jal = 1'b1;  m.jalr = 1'b1;
      return m;
   endfunction

   task automatic push(input string nm, input ex_t e, input ex_t m);
      sb_t s;
      s.e = e;  s.m = m;  s.name = nm;
      sb_q.push_back(s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for ex_valid after a clock edge.
   task automatic wait_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (ex_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic init_regs();
      for (int unsigned i = 1; i < 32; i++) begin
         wb_wen = 1'b1;  wb_rd = i[4:0];  wb_data = 32'h1000_0000 + i * 32'h111;
         rf_m[i] = wb_data;
         step();
      end
      wb_wen = 1'b0;
      rf_m[0] = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      de_valid = 1'b1;  de_insn = 32'h0050_0093;
      repeat (3) step();
      de_valid = 1'b0;
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
      n_checks++;
      if (ex_wen !== 1'b0) begin n_fail++; $display("FAIL reset_ex_wen: got %b want 0", ex_wen); end
      n_checks++;
      if ({ex_op1_pc, ex_op1_zero, ex_op2_imm, ex_load, ex_store, ex_branch, ex_jal, ex_jalr} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {ex_op1_pc, ex_op1_zero, ex_op2_imm, ex_load, ex_store, ex_branch, ex_jal, ex_jalr});
      end
      n_checks++;
      if (ex_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", ex_illegal); end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL reset_de_stall: got %b want 0", de_stall); end
      step();
   endtask

   task automatic test_addi();
      bit ok;
      sb_t s;
      de_valid = 1'b1;  de_pc = 32'h8000_0000;  de_insn = 32'h0050_0093;
      push("addi", mk(32'h8000_0000, 32'h0, rf_m[5], 32'd5, 5'd1, 1'b1, 4'b0000,
                      8'b0010_0000, 3'b000, 1'b0), mask_all());
      wait_issue(ok);
      de_valid = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      sb_t s;
      de_valid = 1'b1;  de_pc = 32'h8000_0004;  de_insn = 32'h0050_0093;
      push("b2b_addi", mk(32'h8000_0004, 32'h0, rf_m[5], 32'd5, 5'd1, 1'b1, 4'b0000,
                          8'b0010_0000, 3'b000, 1'b0), mask_all());
      wait_issue(ok);
      s = sb_q.pop_front();
      n_checks++;
      if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
      end
      de_pc = 32'h8000_0008;  de_insn = 32'h0010_8133;
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_ex: got %b want 1", de_stall); end
      step();
      de_insn = 32'hdead_beef;
      mm_valid = 1'b1;  mm_wen = 1'b1;  mm_rd = 5'd1;
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_mm: got %b want 1", de_stall); end
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %b want 0", ex_valid); end
      step();
      mm_valid = 1'b0;  mm_wen = 1'b0;
      wb_wen = 1'b1;  wb_rd = 5'd1;  wb_data = 32'd5;
      rf_m[1] = 32'd5;
      push("b2b_add", mk(32'h8000_0008, 32'd5, 32'd5, 32'h0, 5'd2, 1'b1, 4'b0000,
                         8'b0000_0000, 3'b000, 1'b0), mask_noimm());
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_wb_release: got %b want 0", de_stall); end
      step();
      wb_wen = 1'b0;  de_valid = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (ex_valid !== 1'b1 || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h valid=%b", s.name, obs & s.m, s.e & s.m, ex_valid);
      end
   endtask

   task automatic test_ex_stall();
      bit ok;
      sb_t s;
      ex_t held_e;
      de_valid = 1'b1;  de_pc = 32'h8000_0010;  de_insn = 32'h0070_0313;
      push("stall_addi", mk(32'h8000_0010, 32'h0, rf_m[7], 32'd7, 5'd6, 1'b1, 4'b0000,
                            8'b0010_0000, 3'b000, 1'b0), mask_all());
      wait_issue(ok);
      s = sb_q.pop_front();
      held_e = s.e;
      n_checks++;
      if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
      end
      de_pc = 32'h8000_0014;  de_insn = 32'h4020_81b3;  ex_stall = 1'b1;
      push("stall_sub", mk(32'h8000_0014, rf_m[1], rf_m[2], 32'h0, 5'd3, 1'b1, 4'b1000,
                           8'b0000_0000, 3'b000, 1'b0), mask_noimm());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (de_stall !== 1'b1) begin n_fail++; $display("FAIL stall_de_stall[%0d]: got %b want 1", i, de_stall); end
         step();
         de_insn = 32'hdead_beef;
         n_checks++;
         if (ex_valid !== 1'b1 || obs !== held_e) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h valid=%b want %h", i, obs, ex_valid, held_e);
         end
      end
      ex_stall = 1'b0;
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", de_stall); end
      step();
      de_valid = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (ex_valid !== 1'b1 || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h valid=%b", s.name, obs & s.m, s.e & s.m, ex_valid);
      end
   endtask

   task automatic test_flush();
      ex_stall = 1'b1;
      de_valid = 1'b1;  de_pc = 32'h8000_0020;  de_insn = 32'h0000_0233;
      step();
      de_valid = 1'b0;  de_insn = 32'hdead_beef;  flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL flush_de_stall: got %b want 0", de_stall); end
      n_checks++;
      if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", ex_valid); end
      step();
      flush = 1'b0;
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid: got %b want 0", ex_valid); end
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL flush_unheld: got %b want 0", de_stall); end
      ex_stall = 1'b0;
      step();
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue: got %b want 0", ex_valid); end
   endtask

   task automatic test_decode();
      bit ok;
      sb_t s;
      logic [31:0] insns [4];
      insns[0] = 32'hffff_ffff;
      insns[1] = 32'h4020_81b3;
      insns[2] = 32'h4040_d193;
      insns[3] = 32'hfe20_ac23;
      push("illegal", mk(32'h8000_0100, 32'h0, 32'h0, 32'h0, 5'd31, 1'b0, 4'b0000,
                         8'b0000_0000, 3'b111, 1'b1), mask_illegal());
      push("sub", mk(32'h8000_0104, rf_m[1], rf_m[2], 32'h0, 5'd3, 1'b1, 4'b1000,
                     8'b0000_0000, 3'b000, 1'b0), mask_noimm());
      push("srai", mk(32'h8000_0108, rf_m[1], rf_m[4], 32'h0000_0404, 5'd3, 1'b1, 4'b1101,
                      8'b0010_0000, 3'b101, 1'b0), mask_all());
      push("sw", mk(32'h8000_010c, rf_m[1], rf_m[2], 32'hffff_fff8, 5'd24, 1'b0, 4'b0010,
                    8'b0010_1000, 3'b010, 1'b0), mask_all());
      for (int unsigned k = 0; k < 4; k++) begin
         de_valid = 1'b1;  de_pc = 32'h8000_0100 + 4 * k;  de_insn = insns[k];
         wait_issue(ok);
         de_valid = 1'b0;
         s = sb_q.pop_front();
         n_checks++;
         if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
            n_fail++;
            $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
         end
      end
   endtask

   task automatic test_x0();
      bit ok;
      sb_t s;
      wb_wen = 1'b1;  wb_rd = 5'd0;  wb_data = 32'h1234;
      step();
      de_valid = 1'b1;  de_pc = 32'h8000_0200;  de_insn = 32'h0000_0233;
      push("x0_read", mk(32'h8000_0200, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 4'b0000,
                         8'b0000_0000, 3'b000, 1'b0), mask_noimm());
      wait_issue(ok);
      de_valid = 1'b0;  wb_wen = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
      end
      de_valid = 1'b1;  de_pc = 32'h8000_0204;  de_insn = 32'h0010_0013;
      push("x0_addi", mk(32'h8000_0204, 32'h0, rf_m[1], 32'd1, 5'd0, 1'b0, 4'b0000,
                         8'b0010_0000, 3'b000, 1'b0), mask_all());
      wait_issue(ok);
      de_valid = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (!ok || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h issued=%0d", s.name, obs & s.m, s.e & s.m, ok);
      end
      mm_valid = 1'b1;  mm_wen = 1'b1;  mm_rd = 5'd0;
      de_valid = 1'b1;  de_pc = 32'h8000_0208;  de_insn = 32'h0000_0233;
      push("x0_nohaz", mk(32'h8000_0208, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 4'b0000,
                          8'b0000_0000, 3'b000, 1'b0), mask_noimm());
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL x0_de_stall: got %b want 0", de_stall); end
      step();
      de_valid = 1'b0;  mm_valid = 1'b0;  mm_wen = 1'b0;
      s = sb_q.pop_front();
      n_checks++;
      if (ex_valid !== 1'b1 || ((obs & s.m) !== (s.e & s.m))) begin
         n_fail++;
         $display("FAIL %s: got %h want %h valid=%b", s.name, obs & s.m, s.e & s.m, ex_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      ex_stall = 1'b1;
      de_valid = 1'b1;  de_pc = 32'h8000_0300;  de_insn = 32'h0050_0093;
      step();
      reset_n = 1'b0;  de_valid = 1'b0;
      step();
      reset_n = 1'b1;
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_ex_valid: got %b want 0", ex_valid); end
      @(negedge clk);
      n_checks++;
      if (de_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_unheld: got %b want 0", de_stall); end
      ex_stall = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      init_regs();
      test_addi();
      test_back_to_back();
      test_ex_stall();
      test_flush();
      test_decode();
      test_x0();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
